uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter, the transmit side of the system's serial link; serialises parallel words onto TX_OUT.
- Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
- Runs on the baud-rate clock from the clock divider, one clk cycle per bit, so no oversampling.
- Holds the last frame so the link controller can request a retransmission after the far-end receiver flags an error.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal range 5..9)

Ports:
clk  input  1  baud-rate clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  word to transmit; sampled only on acceptance
DATA_VALID  input  1  level request: P_DATA holds a new word
PAR_EN  input  1  1 = append parity bit; sampled on acceptance
PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
retx_req  input  1  level request to resend the last frame
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  high while state != IDLE
data_ack  output  1  one-cycle pulse: P_DATA was consumed

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: TX_OUT=1, busy=0, data_ack=0, state=IDLE, bit counter=0, frame shadow register (data/PAR_EN/PAR_TYP)=0.
- Reset has priority at any point, including mid-frame: on the next edge TX_OUT=1 and state=IDLE. No partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance point: the edge where state is IDLE, or the edge ending the STOP cycle.
- At an acceptance point:
  - retx_req=1: the held shadow frame is resent; data_ack stays 0; DATA_VALID is ignored this time.
  - else DATA_VALID=1: P_DATA, PAR_EN and PAR_TYP are latched into the shadow; data_ack=1 for exactly one cycle.
  - else: go to or stay in IDLE.
- Both request paths go to START.
- Retransmit in IDLE after reset sends the reset shadow: data 0x00, no parity.
- Sequence after the acceptance edge:
  - START: TX_OUT=0 for 1 cycle.
  - DATA: DATA_WIDTH cycles, shadow bit 0 first; bit counter 0..DATA_WIDTH-1.
  - PARITY: only if the latched PAR_EN=1; 1 cycle; bit = XOR(data) XOR PAR_TYP.
  - STOP: TX_OUT=1 for 1 cycle.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity (8N1 = 10, 8E1 = 11).
- Back-to-back: a request present at the end of STOP goes straight to START, with no idle cycle. Sustained throughput is one frame per frame-length.
- Changes to P_DATA, PAR_EN or PAR_TYP while busy have no effect on the frame in flight.
- DATA_VALID while busy, outside an acceptance point: not consumed and not lost. The word is taken at the next acceptance point if still asserted.
- Upstream holds DATA_VALID until data_ack and deasserts it in the cycle after data_ack. A still-high DATA_VALID after that is treated as a new word.
- retx_req is level; the controller drops it after seeing busy rise. If still high at the next acceptance point, the frame is resent again.
- busy: registered decode of state; 1 from the acceptance edge until the edge that returns to IDLE.
- TX_OUT is driven directly from a register, so there are no combinational glitches on the line.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles (frame = DATA_WIDTH+3, or +4 with parity). The acceptance point is the end of the second stop cycle.
- Undefined: a single stop cycle, as described in Behaviour.

Test Plan:
- Reset, then P_DATA=0xA5, DATA_VALID=1, PAR_EN=0 in IDLE -> data_ack pulses 1 cycle; TX_OUT=0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high 10 cycles, then TX_OUT idles at 1.
- P_DATA=0x5A, PAR_EN=1: PAR_TYP=0 gives parity bit 0; PAR_TYP=1 gives parity bit 1 -> 11-cycle frame, stop=1 in cycle 11.
- DATA_VALID held with 0x11 then 0x22 (switched after the first data_ack) -> two frames with no idle cycle between; data_ack exactly twice; busy stays high 20 cycles.
- After 0xC3 frame, assert retx_req at the end of STOP while DATA_VALID=1 with 0x3C -> 0xC3 resent, no data_ack; 0x3C is acked and sent in the following frame.
- Assert rst for 1 cycle in the 4th data bit of a frame -> next cycle TX_OUT=1, busy=0, data_ack=0. A new DATA_VALID then produces a clean full frame.
- With UART_TX_TWO_STOP_EN defined, 0xFF 8N1 -> TX_OUT low 1 cycle then high 10 cycles (8 data + 2 stop); next acceptance only after the 11th cycle.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - Upstream handshake and serial line bundle for uart_tx_frame
//
// Purpose: groups the word handshake, retransmit request and transmitter
// outputs so the transmitter and its upstream share one connection.
// Signals:
//   P_DATA      word to transmit (upstream -> tx)
//   DATA_VALID  level request, P_DATA holds a new word (upstream -> tx)
//   PAR_EN      append parity bit (upstream -> tx)
//   PAR_TYP     0 = even, 1 = odd parity (upstream -> tx)
//   retx_req    level request to resend the held frame (upstream -> tx)
//   TX_OUT      registered serial line, idle high (tx -> upstream/line)
//   busy        transmitter not idle (tx -> upstream)
//   data_ack    one-cycle pulse, P_DATA consumed (tx -> upstream)
// Modports: master = upstream/link controller, slave = transmitter.

interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  retx_req;
    logic                  TX_OUT;
    logic                  busy;
    logic                  data_ack;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, retx_req,
        input  TX_OUT, busy, data_ack
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, retx_req,
        output TX_OUT, busy, data_ack
    );
endinterface

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter with parity and last-frame retransmit
//
// Purpose: serialises a word as start bit, DATA_WIDTH data bits LSB first,
// optional parity bit and stop bit, one clk (baud clock) per bit. The last
// accepted frame is held in a shadow register so it can be resent on request.
// Ports:
//   clk  baud-rate clock, rising edge
//   rst  synchronous reset, active-high
//   bus  uart_tx_frame_if.slave (P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
//        retx_req in; TX_OUT, busy, data_ack out)
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.

module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_frame_if.slave    bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic [DATA_WIDTH-1:0] sh_data_q, sh_data_n;
    logic                  sh_pe_q, sh_pe_n;
    logic                  sh_pt_q, sh_pt_n;
    logic                  tx_q, tx_n;
    logic                  busy_q;
    logic                  ack_q, ack_n;
    logic                  stop_last;
    logic                  accept_pt;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop_q, stop_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_data_q <= '0;
            sh_pe_q   <= 1'b0;
            sh_pt_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sh_data_q <= sh_data_n;
            sh_pe_q   <= sh_pe_n;
            sh_pt_q   <= sh_pt_n;
            tx_q      <= tx_n;
            busy_q    <= (state_n != IDLE);
            ack_q     <= ack_n;
`ifdef UART_TX_TWO_STOP_EN
            stop_q    <= stop_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        sh_data_n = sh_data_q;
        sh_pe_n   = sh_pe_q;
        sh_pt_n   = sh_pt_q;
        ack_n     = 1'b0;
        tx_n      = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        stop_n    = stop_q;
        stop_last = stop_q;
`else
        stop_last = 1'b1;
`endif
        accept_pt = (state_q == IDLE) || ((state_q == STOP) && stop_last);

        case (state_q)
            START: begin
                state_n = DATA;
                cnt_n   = '0;
            end
            DATA: begin
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_n = sh_pe_q ? PARITY : STOP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            PARITY: state_n = STOP;
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                stop_n = ~stop_q;
`endif
            end
            default: state_n = IDLE;
        endcase

        // Retransmit outranks a new word; a pending DATA_VALID simply waits.
        if (accept_pt) begin
            cnt_n = '0;
`ifdef UART_TX_TWO_STOP_EN
            stop_n = 1'b0;
`endif
            if (bus.retx_req) begin
                state_n = START;
            end else if (bus.DATA_VALID) begin
                state_n   = START;
                sh_data_n = bus.P_DATA;
                sh_pe_n   = bus.PAR_EN;
                sh_pt_n   = bus.PAR_TYP;
                ack_n     = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end

        // Line value is decoded from the next state so TX_OUT stays a pure flop.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_data_n[cnt_n];
            PARITY:  tx_n = (^sh_data_n) ^ sh_pt_n;
            default: tx_n = 1'b1;
        endcase
    end

    assign bus.TX_OUT   = tx_q;
    assign bus.busy     = busy_q;
    assign bus.data_ack = ack_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - Directed self-checking bench for uart_tx_frame

module tb_uart_tx_frame;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic pt, input int i);
        if (i == 0)            return 1'b0;
        if (i <= 8)            return d[i-1];
        if (i == 9 && pe)      return (^d) ^ pt;
        return 1'b1;
    endfunction

    // Entered at the negedge of frame cycle 0; leaves at the negedge after the
    // last stop cycle. Optionally raises retx_req and a new word in the last
    // stop cycle so they are seen at the acceptance edge.
    task automatic frame_check(input logic [7:0] d, input logic pe, input logic pt,
                               input logic arm_retx, input logic [7:0] next_word);
        int len;
        len = 9 + int'(pe) + NSTOP;
        for (int i = 0; i < len; i++) begin
            check_eq($sformatf("tx_%0h_c%0d", d, i), {31'b0, bus.TX_OUT}, {31'b0, exp_bit(d, pe, pt, i)});
            check_eq($sformatf("busy_%0h_c%0d", d, i), {31'b0, bus.busy}, 32'd1);
            if (i > 0)
                check_eq($sformatf("ack_%0h_c%0d", d, i), {31'b0, bus.data_ack}, 32'd0);
            if (arm_retx && i == len - 1) begin
                bus.retx_req   = 1'b1;
                bus.DATA_VALID = 1'b1;
                bus.P_DATA     = next_word;
                bus.PAR_EN     = 1'b0;
                bus.PAR_TYP    = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_tx"}, {31'b0, bus.TX_OUT}, 32'd1);
        check_eq({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        check_eq({tag, "_ack"}, {31'b0, bus.data_ack}, 32'd0);
    endtask

    // Request a word from idle, check the ack, then scramble inputs mid-frame.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        check_eq($sformatf("ack_%0h_c0", d), {31'b0, bus.data_ack}, 32'd1);
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = ~d;
        bus.PAR_EN     = ~pe;
        bus.PAR_TYP    = ~pt;
        frame_check(d, pe, pt, 1'b0, 8'h00);
        check_idle($sformatf("idle_after_%0h", d));
    endtask

    initial begin
        rst            = 1'b1;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.retx_req   = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // 8N1, then even and odd parity with identical data
        send(8'hA5, 1'b0, 1'b0);
        send(8'h5A, 1'b1, 1'b0);
        send(8'h5A, 1'b1, 1'b1);

        // Back-to-back words with DATA_VALID held high
        bus.P_DATA     = 8'h11;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        check_eq("b2b_ack1", {31'b0, bus.data_ack}, 32'd1);
        bus.P_DATA = 8'h22;
        frame_check(8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("b2b_ack2", {31'b0, bus.data_ack}, 32'd1);
        bus.DATA_VALID = 1'b0;
        frame_check(8'h22, 1'b0, 1'b0, 1'b0, 8'h00);
        check_idle("b2b_idle");

        // Retransmit wins over a pending word at the end of STOP
        bus.P_DATA     = 8'hC3;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        check_eq("c3_ack", {31'b0, bus.data_ack}, 32'd1);
        bus.DATA_VALID = 1'b0;
        frame_check(8'hC3, 1'b0, 1'b0, 1'b1, 8'h3C);
        check_eq("retx_no_ack", {31'b0, bus.data_ack}, 32'd0);
        bus.retx_req = 1'b0;
        frame_check(8'hC3, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("3c_ack", {31'b0, bus.data_ack}, 32'd1);
        bus.DATA_VALID = 1'b0;
        frame_check(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
        check_idle("retx_idle");

        // Reset during the 4th data bit aborts the frame
        bus.P_DATA     = 8'h96;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        check_eq("96_ack", {31'b0, bus.data_ack}, 32'd1);
        bus.DATA_VALID = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("96_bit3", {31'b0, bus.TX_OUT}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midframe_reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("midframe_reset_hold");

        // Retransmit straight after reset sends the cleared shadow frame
        bus.retx_req = 1'b1;
        @(negedge clk);
        check_eq("retx_rst_ack", {31'b0, bus.data_ack}, 32'd0);
        bus.retx_req = 1'b0;
        frame_check(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_idle("retx_rst_idle");

        send(8'h6B, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
